// File: rtl/lpc_synth.sv
// All-pole LPC synthesis filter: gain-scaled excitation plus sum of a_k*y[n-k],
// evaluated one tap per cycle on a single multiplier-accumulator, saturated to 16 bits.
module lpc_synth #(
  parameter int ORDER = 10,
  parameter int FRAC  = 14,
  parameter int ACCW  = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  output logic               in_ready,
  input  logic [15:0]        gain,
  input  logic               coef_we,
  input  logic [3:0]         coef_addr,
  input  logic signed [15:0] coef_data,
  input  logic               hist_clr,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  output logic               coef_err
);

  typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

  localparam logic [3:0]             LAST = 4'(ORDER);
  localparam logic signed [ACCW-1:0] YMAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] YMIN = ACCW'(-32768);

  state_t                 state, state_nxt;
  logic [3:0]             k;
  logic signed [ACCW-1:0] acc, acc_shr;
  logic signed [15:0]     coef [1:ORDER];
  logic signed [15:0]     hist [1:ORDER];
  logic                   clr_pend;
  logic signed [32:0]     xg;
  logic signed [31:0]     prod;
  logic signed [15:0]     coef_k, hist_k, ysat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC:     if (k == LAST) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    xg      = in_data * $signed({1'b0, gain});
    coef_k  = coef[k];
    hist_k  = hist[k];
    prod    = coef_k * hist_k;
    acc_shr = acc >>> FRAC;
    if (acc_shr > YMAX)      ysat = 16'sh7FFF;
    else if (acc_shr < YMIN) ysat = -16'sh8000;
    else                     ysat = acc_shr[15:0];
  end

  // A history clear seen while busy is remembered and applied on the next IDLE
  // edge, ahead of any sample accepted on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      k         <= '0;
      clr_pend  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      for (int i = 1; i <= ORDER; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      coef_err  <= coef_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (coef_we && coef_addr != 4'd0 && coef_addr <= LAST)
            coef[coef_addr] <= coef_data;
          if (hist_clr || clr_pend) begin
            for (int i = 1; i <= ORDER; i++) hist[i] <= '0;
            clr_pend <= 1'b0;
          end
          if (in_valid) begin
            acc <= ACCW'(xg >>> 15) <<< FRAC;
            k   <= 4'd1;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          k   <= k + 4'd1;
          if (hist_clr) clr_pend <= 1'b1;
        end
        WB: begin
          out_data  <= ysat;
          out_valid <= 1'b1;
          hist[1]   <= ysat;
          for (int i = 2; i <= ORDER; i++) hist[i] <= hist[i-1];
          if (hist_clr) clr_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_synth.sv
// Directed bench for lpc_synth: vector table of coefficient/sample/expected records
// plus hand-written sequences for decay, busy-time writes, throughput and reset.
module tb_lpc_synth;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic [15:0]        gain;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               hist_clr;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               coef_err;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [15:0] c;
    logic       clr;
    int         x;
    logic [15:0] g;
    int         exp;
  } vec_t;

  vec_t vecs[$];

  lpc_synth dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .gain(gain), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .hist_clr(hist_clr), .out_data(out_data), .out_valid(out_valid), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic writeCoef(input logic [3:0] addr, input logic [15:0] data);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic clearHist();
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
  endtask

  // busyAct: 0 none, 1 coef_we during MAC, 2 hist_clr during MAC
  task automatic applyStimulus(input string name, input int x, input logic [15:0] g,
                               input int exp, input int busyAct, input int expErr);
    int lat = 0;
    int errs = 0;
    checkOutput({name, " ready"}, int'(in_ready), 1);
    in_valid = 1'b1; in_data = 16'(x); gain = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({name, " busy"}, int'(in_ready), 0);
    for (int c = 1; c <= 40; c++) begin
      if (c == 2 && busyAct == 1) begin
        coef_we = 1'b1; coef_addr = 4'd1; coef_data = 16'h4000;
      end
      if (c == 2 && busyAct == 2) hist_clr = 1'b1;
      @(posedge clk); #1;
      coef_we = 1'b0; hist_clr = 1'b0;
      if (coef_err) errs++;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      checkOutput({name, " timeout"}, 0, 1);
    end else begin
      checkOutput({name, " data"}, int'(out_data), exp);
      checkOutput({name, " latency"}, lat, 11);
      checkOutput({name, " ready_at_valid"}, int'(in_ready), 1);
      checkOutput({name, " coef_err"}, errs, expErr);
      @(posedge clk); #1;
      checkOutput({name, " pulse"}, int'(out_valid), 0);
      checkOutput({name, " hold"}, int'(out_data), exp);
    end
  endtask

  initial begin
    int firstAt, secondAt, seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; gain = 16'h8000;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; hist_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset coef_err", int'(coef_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-pole decay, a1 = 0.5
    writeCoef(4'd1, 16'h2000);
    clearHist();
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("decay%0d", i), (i == 0) ? 16384 : 0, 16'h8000, 16384 >>> i, 0, 0);

    //                we  addr  coef     clr  x       gain     exp
    vecs.push_back('{1'b1, 4'd1, 16'h0000, 1'b1, 1000,   16'h8000, 1000});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b1, -1001,  16'h4000, -501});
    vecs.push_back('{1'b1, 4'd1, 16'h2000, 1'b1, -3,     16'h8000, -3});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, -2});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, -1});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, -1});
    vecs.push_back('{1'b1, 4'd1, 16'h6000, 1'b1, 20000,  16'h8000, 20000});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, 30000});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, 32767});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, 32767});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b1, -20000, 16'h8000, -20000});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, -30000});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, -32768});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, -32768});
    vecs.push_back('{1'b1, 4'd1, 16'h0000, 1'b1, 0,      16'h8000, 0});
    vecs.push_back('{1'b1, 4'd10, 16'h4000, 1'b1, 100,   16'h8000, 100});
    for (int i = 0; i < 9; i++)
      vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,    16'h8000, 0});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, 100});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 0,      16'h8000, 0});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 32767,  16'hFFFF, 32767});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, -32768, 16'hFFFF, -32768});
    vecs.push_back('{1'b0, 4'd0, 16'h0000, 1'b0, 12345,  16'h0000, 0});

    foreach (vecs[i]) begin
      if (vecs[i].we) writeCoef(vecs[i].addr, vecs[i].c);
      if (vecs[i].clr) clearHist();
      applyStimulus($sformatf("vec%0d", i), vecs[i].x, vecs[i].g, vecs[i].exp, 0, 0);
    end

    // Coefficient write during MAC is dropped; a1 stays 0 so the next zero sample stays 0
    clearHist();
    applyStimulus("busy_we", 500, 16'h8000, 500, 1, 1);
    applyStimulus("busy_we_after", 0, 16'h8000, 0, 0, 0);

    // History clear during MAC is deferred, then wipes the 700 before the next sample
    applyStimulus("busy_clr", 700, 16'h8000, 700, 2, 0);
    writeCoef(4'd1, 16'h4000);
    applyStimulus("busy_clr_after", 0, 16'h8000, 0, 0, 0);

    // Back-to-back throughput with in_valid held high
    writeCoef(4'd1, 16'h0000);
    writeCoef(4'd10, 16'h0000);
    clearHist();
    firstAt = 0; secondAt = 0; seen = 0;
    in_valid = 1'b1; in_data = 16'sd50; gain = 16'h8000;
    for (int c = 1; c <= 60 && seen < 2; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        seen++;
        if (seen == 1) firstAt = c;
        else begin
          secondAt = c;
          in_valid = 1'b0;
        end
        checkOutput("thru data", int'(out_data), 50);
      end
    end
    in_valid = 1'b0;
    checkOutput("thru count", seen, 2);
    checkOutput("thru period", secondAt - firstAt, 12);
    repeat (14) @(posedge clk);
    #1;

    // Async reset in the third MAC cycle
    writeCoef(4'd1, 16'h4000);
    clearHist();
    applyStimulus("pre_reset", 777, 16'h8000, 777, 0, 0);
    in_valid = 1'b1; in_data = 16'sd1000; gain = 16'h8000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst out_data", int'(out_data), 0);
    checkOutput("rst out_valid", int'(out_valid), 0);
    checkOutput("rst in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("rst no_valid", seen, 0);
    applyStimulus("post_rst", 1000, 16'h8000, 1000, 0, 0);
    applyStimulus("post_rst_coef0", 0, 16'h8000, 0, 0, 0);
    writeCoef(4'd1, 16'h0000);
    applyStimulus("post_rst_pass", 1234, 16'h8000, 1234, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/lpc_synth.md
# lpc_synth

All-pole LPC synthesis filter that sits directly downstream of the pulse/excitation generator in the LinearPrediction chain. Each accepted excitation sample is scaled by a frame gain, then the block adds ORDER predictor taps over past outputs using one multiplier-accumulator. The result is saturated to 16 bits and emitted as the reconstructed speech sample. Per-frame coefficients are loaded through a simple register-write port between samples.

## Interface
- ORDER, 10, predictor order P (1..15).
- FRAC, 14, fractional bits of coefficients (Q2.14 signed).
- ACCW, 40, accumulator width (must be at least 32+ceil(log2(P+1))+1).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  excitation sample present on in_data.
- in_data  in  16  signed excitation sample (pulsegen output or noise).
- in_ready  out  1  block idle and able to accept a sample.
- gain  in  16  unsigned Q1.15 gain (0x8000 = 1.0); sampled on acceptance.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  tap index k, 1..ORDER; 0 and >ORDER are ignored.
- coef_data  in  16  signed Q2.14 coefficient a_k.
- hist_clr  in  1  zero the output history (filter state).
- out_data  out  16  signed synthesized sample, held until the next result.
- out_valid  out  1  one-cycle pulse: out_data updated.
- coef_err  out  1  one-cycle pulse: coef_we arrived while busy and was dropped.

## Operation
- The filter computes y[n] = sat16( floor( ( floor(x[n]*gain / 2^15) * 2^FRAC + sum_{k=1..P} a_k*y[n-k] ) / 2^FRAC ) ).
- All shifts are arithmetic, so negative values floor toward -inf.
- Saturation clamps to [-32768, 32767].
- FSM states:
  - IDLE: in_ready=1. On in_valid, load acc with the scaled excitation, set k=1, go to MAC.
  - MAC: each cycle acc += a_k*hist[k] and k++. After k=P, go to WB.
  - WB: out_data <= sat(acc>>>FRAC), out_valid=1, history shifts (hist[1]<=y, hist[k]<=hist[k-1]), go to IDLE.
- Coefficient and history storage:
  - Coefficients live in ORDER 16-bit registers.
  - coef_we in IDLE writes at that edge, and the new value is used by the next accepted sample.
  - coef_we in MAC or WB is dropped and coef_err pulses the following cycle.
- hist_clr:
  - In IDLE, it zeroes all history registers at that edge.
  - In MAC or WB, it is held off and applied on the first IDLE cycle.
  - If in_valid and hist_clr are both present in IDLE, the clear applies first and the sample uses zero history.
- The accumulator never wraps: the ACCW default covers the full-scale sum.
- Reset (async, any state):
  - FSM goes to IDLE, and acc, k, coefficients and history are zeroed.
  - out_data=0, out_valid=0, coef_err=0, in_ready=1.
  - A computation in flight is discarded and produces no out_valid.

## Timing
- Sample accepted at edge T (IDLE, in_valid=1). MAC edges are T+1..T+P. out_data and out_valid are registered at edge T+P+1, so latency is P+1 clocks.
- in_ready is decoded from state: low from T+1 through T+P+1, and high again in the same cycle out_valid is high.
- With in_valid held high, the next sample is accepted at T+P+2, giving throughput of one sample per P+2 clocks (12 at ORDER=10).
- in_data is not captured while in_ready=0. The upstream holds it or drops it; no buffering is provided.
- out_data is stable between out_valid pulses.

## Test plan
- Passthrough: all coefficients 0, gain 0x8000, in_data=1000 → out_data=1000 with out_valid exactly 11 clocks after acceptance (ORDER=10).
- Single-pole decay: a1=0x2000 (0.5), others 0, gain 0x8000, impulse 16384 then zeros → 16384, 8192, 4096, 2048, …, reaching 0 after the 15th output. Negative impulse -3 → -3, -2, -1, -1 (floor).
- Saturation: a1=0x6000 (1.5), impulse 20000 → 20000, 30000, 32767, 32767. Repeat with -20000 → -20000, -30000, -32768, -32768.
- Gain scaling: gain 0x4000, coefficients 0, in_data=-1001 → -501 (floor of -500.5).
- Busy-time writes: coef_we during MAC → coef_err pulses once and the coefficient is unchanged; hist_clr during MAC → history is zero for the following sample.
- Async reset at the third MAC cycle → outputs 0 and in_ready=1 immediately, no out_valid follows, coefficients read back as 0. The next passthrough sample (coefficients rewritten) gives an exact value.
